// File: rtl/mode_ctrl_pkg.sv
// mode_ctrl_pkg: shared helpers for mode_controller (one-hot checks, index decode, counter width floor)
package mode_ctrl_pkg;
   localparam int MIN_CNT_W = 1;
   localparam int MAX_MODES = 32;
   function automatic logic is_onehot(input logic [MAX_MODES-1:0] v);
      return (v != '0) && ((v & (v - MAX_MODES'(1))) == '0);
   endfunction
   function automatic int onehot_to_idx(input logic [MAX_MODES-1:0] v);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_MODES; i++) if (v[i]) idx = i;
      return idx;
   endfunction
endpackage

// File: rtl/edge_rise.sv
// edge_rise: rising-edge detector against a registered copy of the input
// ports: clk, rst (sync, active-high), d (level in), rise (d & ~previous d)
module edge_rise import mode_ctrl_pkg::*; (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);
   logic prev;
   always_ff @(posedge clk) prev <= rst ? 1'b0 : d;
   assign rise = d & ~prev;
endmodule

// File: rtl/mode_controller.sv
// mode_controller: one-hot mode selector with step/back, hold-off, lock and button pulses
// ports: clk_i, rst_i (sync, active-high); sel_i direct select; adv_i/back_i step edges;
//        lock_i freezes mode; clr_btn_i/set_btn_i -> rst_o/set_o pulses;
//        state_o one-hot mode, mode_o binary mode, changed_o mode-change strobe
module mode_controller import mode_ctrl_pkg::*; #(
   parameter int N_MODES    = 3,
   parameter int RESET_MODE = 0,
   parameter int HOLDOFF    = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [N_MODES-1:0]         sel_i,
   input  logic                       adv_i,
   input  logic                       back_i,
   input  logic                       lock_i,
   input  logic                       clr_btn_i,
   input  logic                       set_btn_i,
   output logic                       rst_o,
   output logic                       set_o,
   output logic [N_MODES-1:0]         state_o,
   output logic [$clog2(N_MODES)-1:0] mode_o,
   output logic                       changed_o
);
   localparam int MW = $clog2(N_MODES);
   localparam int CW = ($clog2(HOLDOFF + 1) > MIN_CNT_W) ? $clog2(HOLDOFF + 1) : MIN_CNT_W;
   localparam logic [MW-1:0] LAST = MW'(N_MODES - 1);
   logic adv_rise, back_rise, clr_rise, set_rise;
   logic do_adv, do_back, step_ok;
   logic [MW-1:0] mode_q, mode_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [MAX_MODES-1:0] sel_ext;
   edge_rise u_adv (.clk(clk_i), .rst(rst_i), .d(adv_i),     .rise(adv_rise));
   edge_rise u_back(.clk(clk_i), .rst(rst_i), .d(back_i),    .rise(back_rise));
   edge_rise u_clr (.clk(clk_i), .rst(rst_i), .d(clr_btn_i), .rise(clr_rise));
   edge_rise u_set (.clk(clk_i), .rst(rst_i), .d(set_btn_i), .rise(set_rise));
   assign mode_o = mode_q;
   // simultaneous adv/back rises cancel; lock drops any step but the hold-off keeps draining
   always_comb begin
      sel_ext = MAX_MODES'(sel_i);
      do_adv  = adv_rise & ~back_rise;
      do_back = back_rise & ~adv_rise;
      step_ok = (cnt_q == '0) & ~lock_i & (do_adv | do_back);
      cnt_d   = step_ok ? CW'(HOLDOFF) : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      mode_d  = lock_i ? mode_q
              : step_ok ? (do_adv ? ((mode_q == LAST) ? '0 : mode_q + MW'(1))
                                  : ((mode_q == '0) ? LAST : mode_q - MW'(1)))
              : is_onehot(sel_ext) ? MW'(onehot_to_idx(sel_ext))
              : mode_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q    <= MW'(RESET_MODE);
         state_o   <= N_MODES'(1) << RESET_MODE;
         cnt_q     <= '0;
         changed_o <= 1'b0;
         rst_o     <= 1'b0;
         set_o     <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         state_o   <= N_MODES'(1) << mode_d;
         cnt_q     <= cnt_d;
         changed_o <= mode_d != mode_q;
         rst_o     <= clr_rise;
         set_o     <= set_rise;
      end
   end
endmodule

// File: doc/mode_controller.md
# mode_controller

Parametrised one-hot mode controller that sits between the board buttons/clap detector and the datapath blocks whose enables it drives. It generalises the fixed three-mode selector: mode count and reset mode are parameters, the clap/advance input now steps forward or backward through modes from the current mode with wrap-around, and a hold-off window suppresses clap bursts. It adds a lock input, a binary mode index, a mode-change strobe and edge-pulsed reset/set outputs.

## Interface
- N_MODES, 3, number of modes (≥2); width of one-hot state.
- RESET_MODE, 0, mode index loaded on reset (< N_MODES).
- HOLDOFF, 8, cycles during which further advance/back edges are ignored after one is accepted (0 = no hold-off).
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- sel_i  in  N_MODES  direct mode select buttons; bit i requests mode i.
- adv_i  in  1  advance request (clap condition); acts on rising edge.
- back_i  in  1  step-back request; acts on rising edge.
- lock_i  in  1  level; while high, mode is frozen.
- clr_btn_i  in  1  downstream-reset button.
- set_btn_i  in  1  downstream-set button.
- rst_o  out  1  one-cycle pulse on rising edge of clr_btn_i.
- set_o  out  1  one-cycle pulse on rising edge of set_btn_i.
- state_o  out  N_MODES  one-hot current mode.
- mode_o  out  $clog2(N_MODES)  binary index of current mode.
- changed_o  out  1  one-cycle strobe, high in the first cycle a new mode is visible.

## Operation
- Reset: state_o = 1<<RESET_MODE, mode_o = RESET_MODE, changed_o = 0, rst_o = 0, set_o = 0, hold-off counter = 0, all edge-detect history registers = 0.
- Edge detection: adv/back/clr/set each compared with a registered copy; rise = in & ~prev.
- Priority per cycle (highest first): rst_i; lock_i (no mode change, edges still tracked, hold-off keeps counting); step request; direct select.
- Step request: adv rise XOR back rise, accepted only when hold-off counter = 0. Advance: mode ← (mode == N_MODES-1) ? 0 : mode+1. Back: mode ← (mode == 0) ? N_MODES-1 : mode-1. Accepted step loads counter with HOLDOFF. Simultaneous adv and back rises: both discarded, counter unchanged.
- Rejected edges (hold-off active or lock high) are dropped, not queued.
- Direct select: applied only when sel_i is exactly one-hot; mode ← index of the set bit. Zero or multiple bits: hold. Step request wins over sel_i in the same cycle.
- changed_o asserts only when the new mode differs from the old; reselecting the current mode gives no strobe. A reset never produces a strobe.
- Hold-off counter decrements by 1 per cycle while nonzero, saturating at 0; width $clog2(HOLDOFF+1), minimum 1.
- rst_o/set_o are independent of lock_i and mode.

## Timing
- All outputs registered; one-cycle latency from sampled input to output.
- adv_i rising at edge k (sampled high, previous low) → state_o/mode_o/changed_o updated after edge k; changed_o low again after edge k+1.
- After accepted step at edge k, next step accepted no earlier than edge k+HOLDOFF+1.
- adv_i held high for many cycles = exactly one step.
- rst_i mid hold-off: counter cleared, mode to RESET_MODE; an adv rise in the cycle after reset release is accepted.
- state_o and mode_o always consistent; state_o is never zero or multi-hot.

## Structure
- Shared package mode_ctrl_pkg: function onehot_to_idx, function is_onehot, localparam for minimum counter width.
- One sub-module: edge_rise (1-bit registered rising-edge pulse, synchronous reset), instantiated four times.
- Mode stored as binary index; state_o decoded from it and registered.

## Test plan
- Reset with N_MODES=3, RESET_MODE=0 → state_o=3'b001, mode_o=0, all pulses 0; hold sel_i=3'b100 one cycle → state_o=3'b100, changed_o one cycle.
- Three adv_i pulses spaced 10 cycles from mode 2 → modes 0,1,2 (wrap); one back_i pulse from mode 0 → mode 2.
- HOLDOFF=8: adv pulses at cycles 0 and 4 → one step only; pulse at cycle 9 → second step.
- adv_i and back_i rise together → no change, no strobe; adv_i with sel_i=3'b010 from mode 0 → mode 1 via step, strobe once.
- lock_i=1 with adv pulse and sel_i=3'b100 → mode unchanged; clr_btn_i held 5 cycles → rst_o high exactly one cycle.
- N_MODES=5, RESET_MODE=3, sel_i=5'b00110 → hold at mode 3; rst_i during hold-off → mode 3, counter 0, next adv → mode 4.
